uart_tx_frame: RTL and testbench

UART transmitter: the transmit-side counterpart of the receive path's start-bit edge detector and frame FSM. It accepts a parallel byte with a single-cycle valid and serialises it onto tx_out as one frame, LSB first: start bit, 8 data bits, optional parity bit, then stop bit. Bit timing comes from an internal baud counter, so no external tick is needed. It sits between the host-side byte source and the serial pin.

---
 rtl/uart_tx_frame.sv | 156 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, stop.
// Bit timing comes from an internal baud counter; tx_out is registered and idles high.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  tx_arst_n,
  input  logic                  tx_rst,
  input  logic                  tx_en,
  input  logic                  data_valid,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [CW-1:0]         r_baud_cnt, w_baud_cnt_nxt;
  logic [IW-1:0]         r_bit_idx, w_bit_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  r_par_en, w_par_en_nxt;
  logic                  r_par_bit, w_par_bit_nxt;
  logic                  r_tx_out, w_tx_out_nxt;
  logic                  r_done, w_done_nxt;

  logic                  w_bit_end;
  logic                  w_last_bit;
  logic [IW-1:0]         w_idx_inc;

  assign w_bit_end  = (r_baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_last_bit = (r_bit_idx == IW'(DATA_WIDTH - 1));
  assign w_idx_inc  = r_bit_idx + 1'b1;

  always_ff @(posedge clk or negedge tx_arst_n) begin
    if (!tx_arst_n) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_done     <= 1'b0;
    end else if (tx_rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_tx_out   <= 1'b1;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_tx_out   <= w_tx_out_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_tx_out_nxt   = r_tx_out;
    w_done_nxt     = 1'b0;

    if (!tx_en) begin
      w_state_nxt    = IDLE;
      w_baud_cnt_nxt = '0;
      w_bit_idx_nxt  = '0;
      w_tx_out_nxt   = 1'b1;
    end else begin
      if (r_state != IDLE) begin
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
      end
      case (r_state)
        IDLE: begin
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_tx_out_nxt   = 1'b1;
          if (data_valid) begin
            // Frame settings are frozen here; later changes wait for the next frame.
            w_state_nxt   = START;
            w_shift_nxt   = p_data;
            w_par_en_nxt  = par_en;
            w_par_bit_nxt = (^p_data) ^ par_typ;
            w_tx_out_nxt  = 1'b0;
          end
        end
        START: begin
          if (w_bit_end) begin
            w_state_nxt   = DATA;
            w_bit_idx_nxt = '0;
            w_tx_out_nxt  = r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (w_last_bit) begin
              w_state_nxt  = r_par_en ? PARITY : STOP;
              w_tx_out_nxt = r_par_en ? r_par_bit : 1'b1;
            end else begin
              w_bit_idx_nxt = w_idx_inc;
              w_tx_out_nxt  = r_shift[w_idx_inc];
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            w_state_nxt  = STOP;
            w_tx_out_nxt = 1'b1;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            w_state_nxt  = IDLE;
            w_tx_out_nxt = 1'b1;
            w_done_nxt   = 1'b1;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_baud_cnt_nxt = '0;
          w_tx_out_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign tx_out = r_tx_out;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - directed bench for uart_tx_frame with CLKS_PER_BIT=4.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       tx_arst_n, tx_rst, tx_en, data_valid, par_en, par_typ;
  logic [7:0] p_data;
  logic       tx_out, busy, done;

  int n_total = 0;
  int n_bad   = 0;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8)) dut (
    .clk(clk), .tx_arst_n(tx_arst_n), .tx_rst(tx_rst), .tx_en(tx_en),
    .data_valid(data_valid), .p_data(p_data), .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Strobe one byte at a negedge, then check every cycle of the frame.
  // Returns at the negedge of the done cycle so a caller may strobe again there.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic pen,
                           input logic pt, input logic exp_par, input int inj);
    int  nb;
    int  k;
    logic exp_bit;
    p_data = d; par_en = pen; par_typ = pt; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    nb = pen ? 11 : 10;
    for (int b = 0; b < nb; b++) begin
      if (b == 0)                 exp_bit = 1'b0;
      else if (b <= 8)            exp_bit = d[b-1];
      else if (pen && b == 9)     exp_bit = exp_par;
      else                        exp_bit = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        k = b * CPB + c;
        chk($sformatf("%s tx b%0d c%0d", tag, b, c), tx_out, exp_bit);
        chk($sformatf("%s busy k%0d", tag, k), busy, 1'b1);
        chk($sformatf("%s done k%0d", tag, k), done, 1'b0);
        if (k == inj) begin
          data_valid = 1'b1; p_data = 8'hFF; par_en = ~pen; par_typ = ~pt;
        end else begin
          data_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    data_valid = 1'b0;
    chk({tag, " done end"}, done, 1'b1);
    chk({tag, " busy end"}, busy, 1'b0);
    chk({tag, " tx end"}, tx_out, 1'b1);
  endtask

  task automatic strobe(input logic [7:0] d, input logic pen, input logic pt);
    p_data = d; par_en = pen; par_typ = pt; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  initial begin
    tx_arst_n = 1'b0; tx_rst = 1'b0; tx_en = 1'b1; data_valid = 1'b0;
    par_en = 1'b0; par_typ = 1'b0; p_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst tx", tx_out, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    tx_arst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle tx", tx_out, 1'b1);
    chk("idle busy", busy, 1'b0);

    run_frame("a5", 8'hA5, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);
    chk("a5 post done", done, 1'b0);
    chk("a5 post tx", tx_out, 1'b1);

    run_frame("07e", 8'h07, 1'b1, 1'b0, 1'b1, -1);
    run_frame("07o", 8'h07, 1'b1, 1'b1, 1'b0, -1);
    @(negedge clk);

    run_frame("3c", 8'h3C, 1'b0, 1'b0, 1'b0, 10);
    run_frame("81", 8'h81, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);

    run_frame("00o", 8'h00, 1'b1, 1'b1, 1'b1, -1);
    run_frame("ffo", 8'hFF, 1'b1, 1'b1, 1'b1, -1);
    repeat (3) @(negedge clk);
    chk("idle line", tx_out, 1'b1);

    // Async reset during data bit 3 (cycles 17..20 after the strobe).
    strobe(8'hA5, 1'b0, 1'b0);
    repeat (17) @(negedge clk);
    chk("arst pre busy", busy, 1'b1);
    #2 tx_arst_n = 1'b0;
    #1;
    chk("arst tx now", tx_out, 1'b1);
    chk("arst busy now", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst done", done, 1'b0);
    end
    tx_arst_n = 1'b1;
    @(negedge clk);
    chk("arst rel done", done, 1'b0);
    run_frame("55", 8'h55, 1'b0, 1'b0, 1'b0, -1);
    @(negedge clk);

    // tx_en low during parity bit (cycles 37..40).
    strobe(8'h07, 1'b1, 1'b0);
    repeat (37) @(negedge clk);
    chk("en pre tx par", tx_out, 1'b1);
    chk("en pre busy", busy, 1'b1);
    tx_en = 1'b0;
    @(negedge clk);
    chk("en off tx", tx_out, 1'b1);
    chk("en off busy", busy, 1'b0);
    chk("en off done", done, 1'b0);
    p_data = 8'h00; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    chk("en off ignore busy", busy, 1'b0);
    chk("en off ignore tx", tx_out, 1'b1);
    chk("en off done2", done, 1'b0);
    tx_en = 1'b1;
    @(negedge clk);

    // Synchronous reset during stop bit (cycles 37..40, no parity).
    strobe(8'h3C, 1'b0, 1'b0);
    repeat (37) @(negedge clk);
    chk("srst pre tx", tx_out, 1'b1);
    chk("srst pre busy", busy, 1'b1);
    tx_rst = 1'b1;
    @(negedge clk);
    tx_rst = 1'b0;
    chk("srst tx", tx_out, 1'b1);
    chk("srst busy", busy, 1'b0);
    chk("srst done", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("srst done later", done, 1'b0);
      chk("srst busy later", busy, 1'b0);
    end

    run_frame("a5b", 8'hA5, 1'b0, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
